// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: FSM state encoding, reset PC default and FIFO entry layout.
package cpu_pkg;

    localparam int unsigned INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_DROP
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Power-of-two FIFO of fetched {pc, instr} entries; flush takes priority over push and pop.
module prefetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  fetch_entry_t               push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output fetch_entry_t               head_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/instr_prefetch_unit.sv
// Decoupled instruction fetch: one outstanding imem read at a time, results buffered in
// prefetch_fifo, redirects flush the buffer and discard the in-flight response.
module instr_prefetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic               imem_req_o,
    output logic [31:0]        imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [31:0]        instr_pc_o,
    input  logic               instr_ready_i,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc_i
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   gnt_pc_q, gnt_pc_d;
    logic          pend_q, pend_d;
    logic [31:0]   pend_pc_q, pend_pc_d;

    logic [CW-1:0] count;
    logic [CW-1:0] cnt_after_pop;
    logic          pop, push, room_idle, room_push;
    logic [31:0]   redir_pc;
    fetch_entry_t  head, push_data;

    assign redir_pc      = redirect_pc_i & ~32'h0000_0003;
    assign pop           = instr_valid_o && instr_ready_i && !redirect_i;
    assign cnt_after_pop = count - CW'(pop);
    assign room_idle     = cnt_after_pop < CW'(DEPTH);
    assign room_push     = (cnt_after_pop + CW'(1)) < CW'(DEPTH);
    assign push_data     = '{pc: gnt_pc_q, instr: imem_rdata_i};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            gnt_pc_q   <= '0;
            pend_q     <= 1'b0;
            pend_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            gnt_pc_q   <= gnt_pc_d;
            pend_q     <= pend_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

    // A redirect during WAIT cannot move the address until the grant, so it is parked in pend_*.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        gnt_pc_d   = gnt_pc_q;
        pend_d     = pend_q;
        pend_pc_d  = pend_pc_q;
        push       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (redirect_i) begin
                    fetch_pc_d = redir_pc;
                end else if (room_idle) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_gnt_i) begin
                    gnt_pc_d = fetch_pc_q;
                    pend_d   = 1'b0;
                    if (redirect_i) begin
                        fetch_pc_d = redir_pc;
                        state_d    = ST_DROP;
                    end else if (pend_q) begin
                        fetch_pc_d = pend_pc_q;
                        state_d    = ST_DROP;
                    end else begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = ST_RESP;
                    end
                end else if (redirect_i) begin
                    pend_d    = 1'b1;
                    pend_pc_d = redir_pc;
                end
            end
            ST_RESP: begin
                if (redirect_i) begin
                    fetch_pc_d = redir_pc;
                    state_d    = imem_rvalid_i ? ST_IDLE : ST_DROP;
                end else if (imem_rvalid_i) begin
                    push    = 1'b1;
                    state_d = room_push ? ST_WAIT : ST_IDLE;
                end
            end
            ST_DROP: begin
                if (redirect_i) begin
                    fetch_pc_d = redir_pc;
                end
                if (imem_rvalid_i) begin
                    state_d = (!redirect_i && room_idle) ? ST_WAIT : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    prefetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_i),
        .push_i     (push),
        .push_data_i(push_data),
        .pop_i      (pop),
        .flush_i    (redirect_i),
        .head_o     (head),
        .valid_o    (instr_valid_o),
        .count_o    (count)
    );

    assign imem_req_o  = (state_q == ST_WAIT);
    assign imem_addr_o = fetch_pc_q;
    assign instr_o     = head.instr;
    assign instr_pc_o  = head.pc;

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed per-cycle vectors for instr_prefetch_unit: inputs driven and outputs checked mid-cycle.
module tb_instr_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gnt = 1'b0, rvalid = 1'b0, ready = 1'b0, redir = 1'b0;
    logic [31:0] rdata = '0, rpc = '0;
    logic        req, valid;
    logic [31:0] addr, instr, ipc;

    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    instr_prefetch_unit #(
        .DEPTH   (4),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .imem_req_o   (req),
        .imem_addr_o  (addr),
        .imem_gnt_i   (gnt),
        .imem_rvalid_i(rvalid),
        .imem_rdata_i (rdata),
        .instr_valid_o(valid),
        .instr_o      (instr),
        .instr_pc_o   (ipc),
        .instr_ready_i(ready),
        .redirect_i   (redir),
        .redirect_pc_i(rpc)
    );

    typedef struct {
        logic        gnt, rv, rdy, redir;
        logic [31:0] rdata, rpc;
        logic        e_req, e_valid;
        logic [31:0] e_addr, e_instr, e_pc;
    } vec_t;

    function automatic vec_t V(logic g, logic rv, logic [31:0] rd, logic rdy, logic rr,
                               logic [31:0] rp, logic er, logic [31:0] ea, logic ev,
                               logic [31:0] ei, logic [31:0] ep);
        vec_t v;
        v.gnt = g; v.rv = rv; v.rdata = rd; v.rdy = rdy; v.redir = rr; v.rpc = rp;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc = ep;
        return v;
    endfunction

    function automatic logic [31:0] D(logic [31:0] pc);
        return 32'hC0DE_0000 ^ pc;
    endfunction

    task automatic check(string name, int unsigned row, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
        end
    endtask

    // Called at a negedge: drive the row's inputs, check registered outputs, advance one cycle.
    task automatic step(input vec_t v, input int unsigned row);
        gnt = v.gnt; rvalid = v.rv; rdata = v.rdata; ready = v.rdy; redir = v.redir; rpc = v.rpc;
        #1;
        check("req", row, {31'd0, req}, {31'd0, v.e_req});
        if (v.e_req) check("addr", row, addr, v.e_addr);
        check("valid", row, {31'd0, valid}, {31'd0, v.e_valid});
        if (v.e_valid) begin
            check("instr", row, instr, v.e_instr);
            check("pc", row, ipc, v.e_pc);
        end
        @(negedge clk);
    endtask

    vec_t tbl[$];
    vec_t seq[$];

    initial begin
        // reset, first fetch, fill to DEPTH with ready low, then drain in order
        tbl.push_back(V(0,0,0,           0,0,0, 0,0,    0,0,0));
        tbl.push_back(V(1,0,0,           0,0,0, 1,0,    0,0,0));
        tbl.push_back(V(0,1,32'h2008_0005,1,0,0, 0,0,    0,0,0));
        tbl.push_back(V(1,0,0,           1,0,0, 1,4,    1,32'h2008_0005,0));
        tbl.push_back(V(0,1,D(4),        0,0,0, 0,0,    0,0,0));
        tbl.push_back(V(1,0,0,           0,0,0, 1,8,    1,D(4),4));
        tbl.push_back(V(0,1,D(8),        0,0,0, 0,0,    1,D(4),4));
        tbl.push_back(V(1,0,0,           0,0,0, 1,'hC,  1,D(4),4));
        tbl.push_back(V(0,1,D('hC),      0,0,0, 0,0,    1,D(4),4));
        tbl.push_back(V(1,0,0,           0,0,0, 1,'h10, 1,D(4),4));
        tbl.push_back(V(0,1,D('h10),     0,0,0, 0,0,    1,D(4),4));
        for (int i = 0; i < 4; i++)
            tbl.push_back(V(0,0,0,       0,0,0, 0,0,    1,D(4),4));
        tbl.push_back(V(0,0,0,           1,0,0, 0,0,    1,D(4),4));
        tbl.push_back(V(0,0,0,           1,0,0, 1,'h14, 1,D(8),8));
        tbl.push_back(V(0,0,0,           1,0,0, 1,'h14, 1,D('hC),'hC));
        tbl.push_back(V(0,0,0,           1,0,0, 1,'h14, 1,D('h10),'h10));
        tbl.push_back(V(0,0,0,           0,0,0, 1,'h14, 0,0,0));

        // gnt withheld, redirect mid-wait: old address granted, its data dropped
        seq.push_back(V(0,0,0,           0,0,0,     1,'h14, 0,0,0));
        seq.push_back(V(0,0,0,           0,1,'h100, 1,'h14, 0,0,0));
        seq.push_back(V(0,0,0,           0,0,0,     1,'h14, 0,0,0));
        seq.push_back(V(1,0,0,           0,0,0,     1,'h14, 0,0,0));
        seq.push_back(V(0,1,32'hDEAD_BEEF,0,0,0,    0,0,    0,0,0));
        seq.push_back(V(1,0,0,           0,0,0,     1,'h100,0,0,0));
        seq.push_back(V(0,1,D('h100),    0,0,0,     0,0,    0,0,0));
        seq.push_back(V(1,0,0,           1,0,0,     1,'h104,1,D('h100),'h100));
        // redirect to 0x43 while in RESP; rvalid two cycles later is dropped
        seq.push_back(V(0,0,0,           0,1,'h43,  0,0,    0,0,0));
        seq.push_back(V(0,0,0,           0,0,0,     0,0,    0,0,0));
        seq.push_back(V(0,1,32'hBAD0_0108,0,0,0,    0,0,    0,0,0));
        seq.push_back(V(1,0,0,           0,0,0,     1,'h40, 0,0,0));
        seq.push_back(V(0,1,D('h40),     0,0,0,     0,0,    0,0,0));
        seq.push_back(V(1,0,0,           0,0,0,     1,'h44, 1,D('h40),'h40));
        // redirect + rvalid + ready together on a non-empty FIFO
        seq.push_back(V(0,1,D('h44),     1,1,'h200, 0,0,    1,D('h40),'h40));
        seq.push_back(V(0,0,0,           0,0,0,     0,0,    0,0,0));
        seq.push_back(V(1,0,0,           0,0,0,     1,'h200,0,0,0));

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        foreach (tbl[i]) step(tbl[i], i);
        foreach (seq[i]) step(seq[i], 100 + i);

        // reset while in RESP with rvalid high during and after reset
        rvalid = 1'b1; rdata = 32'h5555_AAAA; gnt = 1'b0; ready = 1'b0; redir = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_req", 200, {31'd0, req}, 32'd0);
        check("rst_valid", 200, {31'd0, valid}, 32'd0);
        check("rst_instr", 200, instr, 32'd0);
        check("rst_pc", 200, ipc, 32'd0);
        check("rst_addr", 200, addr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(V(0,1,32'h5555_AAAA,0,0,0, 0,0, 0,0,0), 201);
        check("post_rst_instr", 201, instr, 32'd0);
        // redirect with same-cycle gnt, then fetch_pc wrap
        step(V(1,0,0,0,1,32'hFFFF_FFFE, 1,0, 0,0,0), 202);
        step(V(0,1,32'h1234_5678,0,0,0, 0,0, 0,0,0), 203);
        step(V(1,0,0,0,0,0, 1,32'hFFFF_FFFC, 0,0,0), 204);
        step(V(0,1,D(32'hFFFF_FFFC),0,0,0, 0,0, 0,0,0), 205);
        step(V(0,0,0,0,0,0, 1,0, 1,D(32'hFFFF_FFFC),32'hFFFF_FFFC), 206);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
